// File: rtl/ibex_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ibex_pkg
// Brief   : Shared types for the instruction-fetch memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package ibex_pkg;

    // One stage of the fetch response delay line.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } instr_rsp_t;

    localparam int unsigned MAX_LATENCY   = 8;
    localparam int unsigned OUTSTANDING_W = 4;

endpackage
`default_nettype wire

// File: rtl/ibex_ram_1r1w.sv
`default_nettype none
// ============================================================================
// Module  : ibex_ram_1r1w
// Brief   : Word RAM with one synchronous read port and one write port.
// Revision: 1.0 - initial release
// ============================================================================
module ibex_ram_1r1w #(
    parameter int unsigned Words = 1024,
    parameter int unsigned AddrW = (Words > 1) ? $clog2(Words) : 1
) (
    input  logic             clk_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [31:0]      rdata_o,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [31:0]      wdata_i
);

    logic [31:0] mem_q [Words];

    // Both ports update with non-blocking assignments, so a read that hits the
    // word being written in the same cycle returns the previous contents.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibex_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : ibex_instr_mem_responder
// Brief   : Instruction fetch memory target with fixed-latency in-order responses.
// Revision: 1.0 - initial release
// ============================================================================
module ibex_instr_mem_responder
    import ibex_pkg::*;
#(
    parameter int unsigned MemWords = 1024,
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int unsigned Latency  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        stall_i,
    input  logic        wr_en_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic [3:0]  outstanding_o
);

    localparam int unsigned IdxW           = $clog2(MemWords);
    localparam int          Depth          = int'(Latency) - 1;
    localparam logic [3:0]  MaxOutstanding = 4'(Latency);
    localparam bit          LatencyOk      = (Latency >= 1) && (Latency <= MAX_LATENCY);

    logic [31:0] rd_offset;
    logic [31:0] wr_offset;
    logic        rd_err;
    logic        wr_hit;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic        valid0_q;
    logic        err0_q;
    instr_rsp_t  stage0;
    instr_rsp_t  rsp_out;
    logic [3:0]  outstanding_d;
    logic [3:0]  outstanding_q;
    logic        unused_wr_lsb;

    assign instr_gnt_o = instr_req_i & ~stall_i;

    // BaseAddr is aligned to the array size, so the range test reduces to the
    // offset bits above the word index being zero.
    assign rd_offset     = instr_addr_i - BaseAddr;
    assign wr_offset     = wr_addr_i - BaseAddr;
    assign rd_err        = (rd_offset[1:0] != 2'b00) | (rd_offset[31:IdxW+2] != '0);
    assign wr_hit        = wr_en_i & (wr_offset[31:IdxW+2] == '0);
    assign ram_re        = instr_gnt_o & ~rd_err;
    assign unused_wr_lsb = ^wr_offset[1:0];

    ibex_ram_1r1w #(
        .Words (MemWords),
        .AddrW (IdxW)
    ) u_ram (
        .clk_i   (clk_i),
        .re_i    (ram_re),
        .raddr_i (rd_offset[IdxW+1:2]),
        .rdata_o (ram_rdata),
        .we_i    (wr_hit),
        .waddr_i (wr_offset[IdxW+1:2]),
        .wdata_i (wr_data_i)
    );

    // Stage 0 flags are registered alongside the RAM read, so the RAM output
    // register serves as the stage 0 data field.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid0_q <= 1'b0;
            err0_q   <= 1'b0;
        end else begin
            valid0_q <= instr_gnt_o;
            err0_q   <= instr_gnt_o & rd_err;
        end
    end

    always_comb begin
        stage0       = '0;
        stage0.valid = valid0_q;
        stage0.err   = err0_q;
        stage0.rdata = (valid0_q & ~err0_q) ? ram_rdata : 32'h0;
    end

    generate
        if (Latency == 1) begin : g_direct
            assign rsp_out = stage0;
        end else begin : g_delay
            instr_rsp_t pipe_q [Depth];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < Depth; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= stage0;
                    for (int i = 1; i < Depth; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign rsp_out = pipe_q[Depth-1];
        end
    endgenerate

    always_comb begin
        outstanding_d = outstanding_q;
        if (instr_gnt_o & ~rsp_out.valid) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (~instr_gnt_o & rsp_out.valid) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= 4'd0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign instr_rvalid_o = rsp_out.valid;
    assign instr_err_o    = rsp_out.err;
    assign instr_rdata_o  = rsp_out.rdata;
    assign outstanding_o  = outstanding_q;

    a_latency_range: assert property (@(posedge clk_i) LatencyOk);
    a_err_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_err_o |-> instr_rvalid_o);
    a_gnt_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_gnt_o |-> instr_req_i);
    a_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_o <= MaxOutstanding);

endmodule
`default_nettype wire

// File: tb/tb_ibex_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ibex_instr_mem_responder
// Brief   : Self-checking bench; three responders (Latency 1, 3, 4) vs a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ibex_instr_mem_responder;

    localparam int          NI    = 3;
    localparam int          WORDS = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        int          inst;
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req     [NI];
    logic [31:0] addr    [NI];
    logic        stall   [NI];
    logic        wr_en   [NI];
    logic [31:0] wr_addr [NI];
    logic [31:0] wr_data [NI];
    logic        gnt     [NI];
    logic        rvalid  [NI];
    logic        err     [NI];
    logic [31:0] rdata   [NI];
    logic [3:0]  outst   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ibex_instr_mem_responder #(
            .MemWords (WORDS),
            .BaseAddr (BASE),
            .Latency  (lat(g))
        ) u_dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .instr_req_i    (req[g]),
            .instr_addr_i   (addr[g]),
            .instr_gnt_o    (gnt[g]),
            .instr_rvalid_o (rvalid[g]),
            .instr_rdata_o  (rdata[g]),
            .instr_err_o    (err[g]),
            .stall_i        (stall[g]),
            .wr_en_i        (wr_en[g]),
            .wr_addr_i      (wr_addr[g]),
            .wr_data_i      (wr_data[g]),
            .outstanding_o  (outst[g])
        );
    end

    // Reference model: word image per instance plus a list of pending responses
    // tagged with the cycle in which each must appear.
    logic [31:0] mdl_mem [NI][WORDS];
    exp_t        pend [$];
    int          cyc = 0;
    logic        g_obs [NI];
    logic        e_gnt [NI];
    logic        e_rv  [NI];
    logic        e_err [NI];
    logic [31:0] e_rd  [NI];
    logic [3:0]  e_out [NI];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic model_err(input logic [31:0] a);
        longint unsigned la = longint'(a);
        longint unsigned lb = longint'(BASE);
        return (a % 4 != 0) || (la < lb) || (la >= lb + longint'(WORDS * 4));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < NI; k++) begin
            req[k] = 1'b0; addr[k] = 32'h0; stall[k] = 1'b0;
            wr_en[k] = 1'b0; wr_addr[k] = 32'h0; wr_data[k] = 32'h0;
        end
    endtask

    // Advance one clock: record grants, update the model, refresh expectations.
    task automatic tick();
        exp_t keep [$];
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            g_obs[k] = gnt[k];
            e_gnt[k] = req[k] & ~stall[k];
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            pend.delete();
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (e_gnt[k]) begin
                    exp_t e;
                    e.inst = k;
                    e.due  = cyc + lat(k);
                    e.err  = model_err(addr[k]);
                    e.data = e.err ? 32'h0 : mdl_mem[k][word_of(addr[k])];
                    pend.push_back(e);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            if (wr_en[k] && !model_err({wr_addr[k][31:2], 2'b00})) begin
                mdl_mem[k][word_of(wr_addr[k])] = wr_data[k];
            end
        end
        cyc++;
        foreach (pend[i]) begin
            if (pend[i].due >= cyc) keep.push_back(pend[i]);
        end
        pend = keep;
        for (int k = 0; k < NI; k++) begin
            e_rv[k] = 1'b0; e_err[k] = 1'b0; e_rd[k] = 32'h0; e_out[k] = 4'd0;
        end
        foreach (pend[i]) begin
            e_out[pend[i].inst] = e_out[pend[i].inst] + 4'd1;
            if (pend[i].due == cyc) begin
                e_rv[pend[i].inst]  = 1'b1;
                e_err[pend[i].inst] = pend[i].err;
                e_rd[pend[i].inst]  = pend[i].data;
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if ({gnt[k], rvalid[k], err[k], rdata[k], outst[k]} !== 39'h0)
                $display("FAIL reset inst%0d: got g%b v%b e%b d%h o%0d want all zero",
                         k, gnt[k], rvalid[k], err[k], rdata[k], outst[k]);
            else n_pass++;
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if ({rvalid[k], outst[k]} !== {e_rv[k], e_out[k]})
                $display("FAIL post_reset inst%0d: got v%b o%0d want v%b o%0d",
                         k, rvalid[k], outst[k], e_rv[k], e_out[k]);
            else n_pass++;
        end
    endtask

    task automatic preload();
        for (int w = 0; w < WORDS; w++) begin
            for (int k = 0; k < NI; k++) begin
                wr_en[k]   = 1'b1;
                wr_addr[k] = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
                wr_data[k] = (k == 0 && w == 32) ? 32'h0010_0093 : ((w == 4) ? 32'h1 : $urandom);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_single();
        clear_inputs();
        req[0] = 1'b1; addr[0] = 32'h80;
        tick();
        n_checks++;
        if (g_obs[0] !== 1'b1) $display("FAIL single_gnt: got %b want 1", g_obs[0]);
        else n_pass++;
        req[0] = 1'b0;
        n_checks++;
        if ({rvalid[0], err[0], rdata[0], outst[0]} !== {1'b1, 1'b0, 32'h0010_0093, 4'd1})
            $display("FAIL single_rsp: got v%b e%b d%h o%0d want v1 e0 d00100093 o1",
                     rvalid[0], err[0], rdata[0], outst[0]);
        else n_pass++;
        tick();
        n_checks++;
        if ({rvalid[0], outst[0]} !== {1'b0, 4'd0})
            $display("FAIL single_drain: got v%b o%0d want v0 o0", rvalid[0], outst[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] peak = 4'd0;
        int         nrv  = 0;
        clear_inputs();
        for (int c = 0; c < 10; c++) begin
            req[1]  = (c < 4);
            addr[1] = 32'(c * 4);
            tick();
            n_checks++;
            if ({g_obs[1], rvalid[1], err[1], rdata[1], outst[1]} !==
                {e_gnt[1], e_rv[1], e_err[1], e_rd[1], e_out[1]})
                $display("FAIL b2b c%0d: got g%b v%b e%b d%h o%0d want g%b v%b e%b d%h o%0d", c,
                         g_obs[1], rvalid[1], err[1], rdata[1], outst[1],
                         e_gnt[1], e_rv[1], e_err[1], e_rd[1], e_out[1]);
            else n_pass++;
            if (outst[1] > peak) peak = outst[1];
            if (rvalid[1] === 1'b1) nrv++;
        end
        n_checks++;
        if (peak !== 4'd3) $display("FAIL b2b_peak: got %0d want 3", peak);
        else n_pass++;
        n_checks++;
        if (nrv != 4) $display("FAIL b2b_count: got %0d rvalids want 4", nrv);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] seq [3];
        int          nerr = 0;
        seq[0] = 32'h82; seq[1] = BASE + 32'(WORDS * 4); seq[2] = 32'h84;
        clear_inputs();
        for (int c = 0; c < 9; c++) begin
            req[2]  = (c < 3);
            addr[2] = (c < 3) ? seq[c] : 32'h0;
            tick();
            n_checks++;
            if ({rvalid[2], err[2], rdata[2], outst[2]} !== {e_rv[2], e_err[2], e_rd[2], e_out[2]})
                $display("FAIL err_rsp c%0d: got v%b e%b d%h o%0d want v%b e%b d%h o%0d", c,
                         rvalid[2], err[2], rdata[2], outst[2], e_rv[2], e_err[2], e_rd[2], e_out[2]);
            else n_pass++;
            if (rvalid[2] === 1'b1 && err[2] === 1'b1) nerr++;
        end
        n_checks++;
        if (nerr != 2) $display("FAIL err_count: got %0d error responses want 2", nerr);
        else n_pass++;
    endtask

    task automatic test_stall();
        clear_inputs();
        req[1] = 1'b1; stall[1] = 1'b1; addr[1] = 32'h20;
        for (int c = 0; c < 9; c++) begin
            stall[1] = (c < 5);
            req[1]   = (c < 6);
            tick();
            n_checks++;
            if ({g_obs[1], rvalid[1], err[1], rdata[1], outst[1]} !==
                {e_gnt[1], e_rv[1], e_err[1], e_rd[1], e_out[1]})
                $display("FAIL stall c%0d: got g%b v%b e%b d%h o%0d want g%b v%b e%b d%h o%0d", c,
                         g_obs[1], rvalid[1], err[1], rdata[1], outst[1],
                         e_gnt[1], e_rv[1], e_err[1], e_rd[1], e_out[1]);
            else n_pass++;
        end
    endtask

    task automatic test_read_before_write();
        clear_inputs();
        req[0] = 1'b1; addr[0] = 32'h10;
        wr_en[0] = 1'b1; wr_addr[0] = 32'h10; wr_data[0] = 32'hDEAD_BEEF;
        tick();
        clear_inputs();
        n_checks++;
        if ({rvalid[0], rdata[0]} !== {1'b1, 32'h1})
            $display("FAIL rbw_old: got v%b d%h want v1 d00000001", rvalid[0], rdata[0]);
        else n_pass++;
        req[0] = 1'b1; addr[0] = 32'h10;
        tick();
        clear_inputs();
        n_checks++;
        if ({rvalid[0], rdata[0]} !== {1'b1, 32'hDEAD_BEEF})
            $display("FAIL rbw_new: got v%b d%h want v1 ddeadbeef", rvalid[0], rdata[0]);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        clear_inputs();
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < NI; k++) begin
                int sel = $urandom_range(0, 9);
                req[k]   = ($urandom_range(0, 3) != 0);
                stall[k] = ($urandom_range(0, 4) == 0);
                addr[k]  = BASE + 32'($urandom_range(0, WORDS - 1)) * 4;
                if (sel == 8) addr[k] = addr[k] + 32'($urandom_range(1, 3));
                if (sel == 9) addr[k] = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC
                                        : BASE + 32'(WORDS * 4) + 32'($urandom_range(0, 255)) * 4;
                wr_en[k]   = ($urandom_range(0, 3) == 0);
                wr_addr[k] = BASE + 32'($urandom_range(0, WORDS + 7)) * 4 + 32'($urandom_range(0, 3));
                wr_data[k] = $urandom;
            end
            tick();
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if ({g_obs[k], rvalid[k], err[k], rdata[k], outst[k]} !==
                    {e_gnt[k], e_rv[k], e_err[k], e_rd[k], e_out[k]})
                    $display("FAIL rand inst%0d cyc%0d: got g%b v%b e%b d%h o%0d want g%b v%b e%b d%h o%0d",
                             k, cyc, g_obs[k], rvalid[k], err[k], rdata[k], outst[k],
                             e_gnt[k], e_rv[k], e_err[k], e_rd[k], e_out[k]);
                else n_pass++;
            end
        end
        clear_inputs();
        for (int c = 0; c < 5; c++) tick();
    endtask

    task automatic test_reset_inflight();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            req[2] = 1'b1; addr[2] = 32'(c * 4);
            tick();
        end
        clear_inputs();
        n_checks++;
        if ({rvalid[2], outst[2]} !== {1'b0, 4'd3})
            $display("FAIL inflight_pre: got v%b o%0d want v0 o3", rvalid[2], outst[2]);
        else n_pass++;
        rst_n = 1'b0;
        pend.delete();
        #1;
        n_checks++;
        if ({rvalid[2], err[2], rdata[2], outst[2]} !== 38'h0)
            $display("FAIL inflight_rst: got v%b e%b d%h o%0d want all zero",
                     rvalid[2], err[2], rdata[2], outst[2]);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if ({rvalid[2], err[2], rdata[2], outst[2]} !== 38'h0)
                $display("FAIL inflight_after c%0d: got v%b e%b d%h o%0d want all zero", c,
                         rvalid[2], err[2], rdata[2], outst[2]);
            else n_pass++;
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        preload();
        test_single();
        test_back_to_back();
        test_errors();
        test_stall();
        test_read_before_write();
        test_random();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
